// File: rtl/zc_cal_sequencer.sv
// Calibration/run sequencer for the I/Q zero-crossing detector pair.
// Clears, calibrates, range-checks offsets with retry, then watches for lost crossings.
module zc_cal_sequencer #(
  parameter int WIDTH       = 16,
  parameter int MAX_RETRY   = 3,
  parameter int MAX_LOG_CAL = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_recal_en,
  input  logic [31:0]      log_cal_len,
  input  logic [31:0]      timeout_samples,
  input  logic [WIDTH-1:0] offset_tol,
  input  logic             i_tvalid,
  input  logic             zc_i_valid,
  input  logic             zc_q_valid,
  input  logic [WIDTH-1:0] offset_i,
  input  logic [WIDTH-1:0] offset_q,
  output logic             det_clear,
  output logic             init_cal,
  output logic [31:0]      cal_log_len_out,
  output logic             running,
  output logic             busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [7:0]       retry_cnt,
  output logic [15:0]      recal_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_CAL    = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_RUN    = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  state_t      st;
  logic [47:0] cal_cnt;
  logic        settle;
  logic [31:0] to_cnt;

  logic [31:0] len_clamp;
  logic [WIDTH:0] ext_i, ext_q, abs_i, abs_q;
  logic        pass;
  logic [31:0] to_next;
  logic        to_hit;

  assign state = st;

  assign len_clamp = (log_cal_len > 32'(MAX_LOG_CAL)) ?
                     32'(MAX_LOG_CAL) : log_cal_len;

  // one extra bit so the most negative offset has a representable magnitude
  assign ext_i = {offset_i[WIDTH-1], offset_i};
  assign ext_q = {offset_q[WIDTH-1], offset_q};
  assign abs_i = ext_i[WIDTH] ? ((WIDTH+1)'(0) - ext_i) : ext_i;
  assign abs_q = ext_q[WIDTH] ? ((WIDTH+1)'(0) - ext_q) : ext_q;
  assign pass  = (abs_i <= {1'b0, offset_tol}) &&
                 (abs_q <= {1'b0, offset_tol});

  assign to_next = to_cnt + 32'd1;
  assign to_hit  = auto_recal_en && (timeout_samples != 32'd0) &&
                   (to_next >= timeout_samples);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      st              <= S_IDLE;
      det_clear       <= 1'b0;
      init_cal        <= 1'b0;
      cal_log_len_out <= 32'd0;
      running         <= 1'b0;
      busy            <= 1'b0;
      cal_done        <= 1'b0;
      cal_fail        <= 1'b0;
      retry_cnt       <= 8'd0;
      recal_cnt       <= 16'd0;
      cal_cnt         <= 48'd0;
      settle          <= 1'b0;
      to_cnt          <= 32'd0;
    end else begin
      det_clear <= 1'b0;
      init_cal  <= 1'b0;
      cal_done  <= 1'b0;
      if (stop && st != S_IDLE) begin
        st      <= S_IDLE;
        running <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (st)
          S_IDLE, S_FAIL: begin
            if (start && !stop) begin
              cal_log_len_out <= len_clamp;
              retry_cnt       <= 8'd0;
              cal_fail        <= 1'b0;
              st              <= S_CLEAR;
              det_clear       <= 1'b1;
              busy            <= 1'b1;
            end
          end
          S_CLEAR: begin
            st       <= S_CAL;
            init_cal <= 1'b1;
            cal_cnt  <= 48'd1 << cal_log_len_out;
          end
          S_CAL: begin
            if (init_cal) begin
              // zero length skips averaging; detector keeps its static offset
              if (cal_log_len_out == 32'd0) begin
                st       <= S_RUN;
                running  <= 1'b1;
                busy     <= 1'b0;
                cal_done <= 1'b1;
                to_cnt   <= 32'd0;
              end
            end else if (i_tvalid) begin
              cal_cnt <= cal_cnt - 48'd1;
              if (cal_cnt == 48'd1) begin
                st     <= S_SETTLE;
                settle <= 1'b0;
              end
            end
          end
          S_SETTLE: begin
            if (settle) st <= S_CHECK;
            else settle <= 1'b1;
          end
          S_CHECK: begin
            if (pass) begin
              st       <= S_RUN;
              running  <= 1'b1;
              busy     <= 1'b0;
              cal_done <= 1'b1;
              to_cnt   <= 32'd0;
            end else if (retry_cnt < 8'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 8'd1;
              st        <= S_CLEAR;
              det_clear <= 1'b1;
            end else begin
              cal_fail <= 1'b1;
              st       <= S_FAIL;
              busy     <= 1'b0;
            end
          end
          S_RUN: begin
            if (zc_i_valid || zc_q_valid) begin
              to_cnt <= 32'd0;
            end else if (i_tvalid) begin
              if (to_hit) begin
                if (recal_cnt != 16'hFFFF) recal_cnt <= recal_cnt + 16'd1;
                cal_log_len_out <= len_clamp;
                retry_cnt       <= 8'd0;
                st              <= S_CLEAR;
                det_clear       <= 1'b1;
                running         <= 1'b0;
                busy            <= 1'b1;
                to_cnt          <= 32'd0;
              end else begin
                to_cnt <= to_next;
              end
            end
          end
          default: begin
            st      <= S_IDLE;
            running <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/zc_cal_sequencer.md
Name: zc_cal_sequencer

Overview:
- Sequences a pair of I/Q zero-crossing detectors in the doppler tracker.
- Clears both detectors, issues the DC-offset calibration pulse, and counts calibration samples.
- Range-checks the resulting offsets and retries on failure, then enables measurement.
- Watches for a loss of crossings and re-calibrates automatically. Sits between the settings bus and both detector instances.

Parameters:
- WIDTH, 16, sample/offset width, matching the detectors.
- MAX_RETRY, 3, calibration retries before declaring failure.
- MAX_LOG_CAL, 40, clamp for log calibration length (detector cal counter is 48-bit).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- clear  in  1  synchronous soft clear; same effect as reset on all state
- start  in  1  single-cycle pulse that begins a calibrate-then-run sequence
- stop  in  1  single-cycle pulse that returns to IDLE
- auto_recal_en  in  1  enables timeout-driven re-calibration
- log_cal_len  in  32  requested log2 calibration length
- timeout_samples  in  32  valid samples without a crossing before re-calibration; 0 disables
- offset_tol  in  WIDTH  maximum allowed |offset|, unsigned
- i_tvalid  in  1  sample strobe of the stream feeding both detectors
- zc_i_valid, zc_q_valid  in  1 each  detector o_tvalid outputs
- offset_i, offset_q  in  WIDTH  detector offset_out, signed
- det_clear  out  1  drives both detectors' clear
- init_cal  out  1  drives both detectors' init_cal
- cal_log_len_out  out  32  clamped length driven to both detectors' log_cal_len
- running  out  1  high in RUN
- busy  out  1  high in CLEAR/CAL/SETTLE/CHECK
- cal_done  out  1  one-cycle pulse on entering RUN
- cal_fail  out  1  sticky failure flag
- retry_cnt  out  8  retries used in the current sequence
- recal_cnt  out  16  timeout re-calibrations since reset/clear; saturates
- state  out  3  current state code

Behaviour:
- State codes: IDLE=0, CLEAR=1, CAL=2, SETTLE=3, CHECK=4, RUN=5, FAIL=6.
- Reset/clear values: state IDLE; det_clear, init_cal, running, busy, cal_done, cal_fail all 0; retry_cnt, recal_cnt, cal_log_len_out and all counters 0.
- IDLE/FAIL, on start:
  - latch cal_log_len_out = min(log_cal_len, MAX_LOG_CAL);
  - zero retry_cnt;
  - go to CLEAR.
  - From FAIL, start also clears cal_fail. start in any other state is ignored.
- CLEAR: det_clear=1 for exactly one cycle, then go to CAL.
- CAL, first cycle:
  - init_cal=1 for exactly one cycle;
  - load the 48-bit sample counter with 1<<cal_log_len_out.
  - If cal_log_len_out==0: pulse cal_done and go directly to RUN next cycle, with no CHECK (detector falls back to its static offset).
- CAL, later cycles: decrement the counter on each i_tvalid, excluding the init_cal cycle. On the decrement to 0, go to SETTLE.
- SETTLE: wait 2 cycles (detector result register plus shift), then go to CHECK.
- CHECK (1 cycle): pass if |offset_i|<=offset_tol and |offset_q|<=offset_tol.
  - Absolute value is computed at WIDTH+1 bits, so -2^(WIDTH-1) is handled.
  - Pass: go to RUN with a cal_done pulse.
  - Fail with retry_cnt<MAX_RETRY: retry_cnt+1, go to CLEAR.
  - Fail otherwise: set cal_fail, go to FAIL.
- RUN: running=1.
  - The 32-bit timeout counter zeroes on entry and on any zc_i_valid or zc_q_valid.
  - Otherwise it increments on i_tvalid.
  - If auto_recal_en and timeout_samples!=0 and the counter reaches timeout_samples: recal_cnt+1 (saturating at 0xFFFF), zero retry_cnt, go to CLEAR.
  - A crossing valid in the same cycle as the count would reach the limit zeroes the counter; no recal.
- stop in any state except IDLE: go to IDLE next cycle. Outputs deassert and cal_fail is preserved. stop wins over a simultaneous start.
- init_cal and det_clear are never high in the same cycle.
- log_cal_len changes after start have no effect until the next start or recal entry. A recal re-latches log_cal_len.
- clear mid-sequence aborts immediately to IDLE with reset values.

Test Plan:
- log_cal_len=4, offsets 5/-3, tol=10, continuous i_tvalid, start → det_clear at cycle 1, init_cal at cycle 2, CHECK after 16 valids plus 2, cal_done, running=1, retry_cnt=0.
- offset_i=50, tol=10, MAX_RETRY=3, start → 4 CLEAR/init_cal sequences, then cal_fail=1, state=FAIL, retry_cnt=3; next start clears cal_fail.
- log_cal_len=0, start → init_cal pulse, then running=1 with cal_done the next cycle and no CHECK; log_cal_len=60 → cal_log_len_out=40.
- RUN with auto_recal_en=1, timeout_samples=100, no crossings → CLEAR after the 100th valid, recal_cnt=1; with zc_q_valid every 50 valids → no recal.
- stop and start in the same cycle while in CAL → IDLE; clear during SETTLE → IDLE, all outputs 0.
- i_tvalid gated at 25% duty during CAL, log_cal_len=3 → SETTLE exactly after the 8th valid, not after 8 cycles.
